// File: rtl/tc_sram_stream_adapter.sv
// tc_sram_stream_adapter
// Bridges a valid/ready request stream onto one single-port tc_sram port and
// returns read data as a valid/ready response stream. A credit counter keeps
// reads in flight plus buffered responses at or below BufDepth, so the
// response FIFO can absorb the fixed SRAM read latency without ever dropping
// data while the consumer stalls. Writes produce no response.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and payload until accepted; the
// response side holds rsp_valid_o and rsp_rdata_o until popped.

module tc_sram_stream_adapter #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned BufDepth  = 2,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // request stream
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    // response stream
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    // SRAM port
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    // status
    output logic                 busy_o
);

    localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned CntWidth = $clog2(BufDepth + 1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(BufDepth);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(BufDepth - 1);

    // credit counter: reads in flight plus FIFO occupancy
    logic [CntWidth-1:0] used_q, used_d;

    // response FIFO state
    logic [DataWidth-1:0] mem_q [BufDepth];
    logic [DataWidth-1:0] mem_d [BufDepth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic rd_accept;      // a read is handed to the SRAM this cycle
    logic rd_data_valid;  // sram_rdata_i carries read data this cycle
    logic fifo_push;
    logic fifo_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (p == PtrLast) begin
            return '0;
        end
        return p + PtrWidth'(1);
    endfunction

    // ------------------------------------------------------------------
    // Request side. Writes never consume a credit; a read may take the
    // credit freed by a pop in the same cycle, which is why rsp_ready_i
    // reaches req_ready_o combinationally.
    // ------------------------------------------------------------------
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign fifo_pop    = rsp_valid_o && rsp_ready_i;

    assign req_ready_o = !rst_i && (req_we_i || (used_q < CntFull) || fifo_pop);
    assign sram_req_o  = req_valid_i && req_ready_o;
    assign rd_accept   = sram_req_o && !req_we_i;

    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    // ------------------------------------------------------------------
    // Read tracking. Accepted reads enter at bit 0 and the bit at the head
    // marks the cycle in which the SRAM presents that read's data. With a
    // combinational SRAM the data is valid in the accept cycle itself.
    // ------------------------------------------------------------------
    if (Latency == 0) begin : g_lat0
        assign rd_data_valid = rd_accept;
    end else begin : g_pipe
        logic [Latency-1:0] pipe_q, pipe_d;

        // shift the accepted-read marker one stage toward the head
        always_comb begin
            pipe_d    = pipe_q << 1;
            pipe_d[0] = rd_accept;
        end

        // read-tracking shift register
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign rd_data_valid = pipe_q[Latency-1];
    end

    assign fifo_push = rd_data_valid;

    // ------------------------------------------------------------------
    // Response FIFO. The head entry drives rsp_rdata_o directly, so a new
    // entry becomes visible only on the edge after its push. When full, a
    // simultaneous push lands in the slot being popped, which is safe
    // because the head leaves on that same edge.
    // ------------------------------------------------------------------

    // next FIFO contents, pointers and occupancy
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = sram_rdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntWidth'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntWidth'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // next credit count: +1 per accepted read, -1 per popped response
    always_comb begin
        case ({rd_accept, fifo_pop})
            2'b10:   used_d = used_q + CntWidth'(1);
            2'b01:   used_d = used_q - CntWidth'(1);
            default: used_d = used_q;
        endcase
    end

    // FIFO and credit registers; reset drops every in-flight read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BufDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            used_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            used_q     <= used_d;
        end
    end

    assign rsp_rdata_o = mem_q[rd_ptr_q];
    assign busy_o      = (used_q != '0);

    // the credit scheme must make FIFO and credit overflow impossible
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (!rst_i) begin
            assert (!(fifo_push && !fifo_pop && (fifo_cnt_q == CntFull)));
            assert (!(rd_accept && !fifo_pop && (used_q == CntFull)));
        end
    end

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Bench for tc_sram_stream_adapter. Three instances share one clock/reset:
// lane 0 Latency=1/BufDepth=2, lane 1 Latency=0/BufDepth=2,
// lane 2 Latency=3/BufDepth=4. Each lane has its own behavioural SRAM.
module tb_tc_sram_stream_adapter;

    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [NL];
    logic        req_ready [NL];
    logic        req_we    [NL];
    logic [9:0]  req_addr  [NL];
    logic [31:0] req_wdata [NL];
    logic [3:0]  req_be    [NL];
    logic        rsp_valid [NL];
    logic        rsp_ready [NL];
    logic [31:0] rsp_rdata [NL];
    logic        sram_req  [NL];
    logic        sram_we   [NL];
    logic [9:0]  sram_addr [NL];
    logic [31:0] sram_wdata[NL];
    logic [3:0]  sram_be   [NL];
    logic [31:0] sram_rdata[NL];
    logic        busy      [NL];

    logic [31:0] exp_q [NL][$];
    logic [31:0] ref_mem [NL][1024];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C3_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic int lat_of(input int l);
        return (l == 0) ? 1 : ((l == 1) ? 0 : 3);
    endfunction

    // ---------------- DUTs and behavioural SRAMs ----------------
    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int L  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int BD = (g == 2) ? 4 : 2;

        tc_sram_stream_adapter #(
            .NumWords (1024),
            .DataWidth(32),
            .ByteWidth(8),
            .Latency  (L),
            .BufDepth (BD)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .req_be_i    (req_be[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .sram_req_o  (sram_req[g]),
            .sram_we_o   (sram_we[g]),
            .sram_addr_o (sram_addr[g]),
            .sram_wdata_o(sram_wdata[g]),
            .sram_be_o   (sram_be[g]),
            .sram_rdata_i(sram_rdata[g]),
            .busy_o      (busy[g])
        );

        logic [31:0] mem [1024];
        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        end
        always @(posedge clk) begin
            if (sram_req[g] && sram_we[g])
                mem[sram_addr[g]] <= apply_be(mem[sram_addr[g]], sram_wdata[g], sram_be[g]);
        end

        if (L == 0) begin : g_comb
            assign sram_rdata[g] = mem[sram_addr[g]];
        end else begin : g_seq
            logic [31:0] pipe [L];
            always @(posedge clk) begin
                pipe[0] <= (sram_req[g] && !sram_we[g]) ? mem[sram_addr[g]] : 32'hBAD0_BAD0;
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
            assign sram_rdata[g] = pipe[L-1];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // scoreboard: compare every popped response with the queue head
    always @(negedge clk) begin
        #3;
        for (int l = 0; l < NL; l++) begin
            if (!rst && rsp_valid[l] && rsp_ready[l]) begin
                if (exp_q[l].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp lane %0d: got %0h, required no response", l, rsp_rdata[l]);
                end else begin
                    check($sformatf("rsp_data_l%0d", l), 64'(rsp_rdata[l]), 64'(exp_q[l].pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input int l, input logic we, input logic [9:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input bit use_exp, input logic [31:0] exp_v);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        @(negedge clk);
        req_valid[l] = 1'b1;
        req_we[l]    = we;
        req_addr[l]  = addr;
        req_wdata[l] = wd;
        req_be[l]    = be;
        while (!done) begin
            #2;
            if (req_ready[l]) begin
                check($sformatf("sram_drive_l%0d", l),
                      64'({sram_req[l], sram_we[l], sram_addr[l], sram_wdata[l], sram_be[l]}),
                      64'({1'b1, we, addr, wd, be}));
                if (we) ref_mem[l][addr] = apply_be(ref_mem[l][addr], wd, be);
                else    exp_q[l].push_back(use_exp ? exp_v : ref_mem[l][addr]);
                done = 1;
            end else if (waited >= 60) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_timeout lane %0d: req_ready 0, required 1 within 60 cycles", l);
                done = 1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        req_valid[l] = 1'b0;
    endtask

    task automatic drain(input int l);
        int n;
        n = 0;
        rsp_ready[l] = 1'b1;
        @(negedge clk);
        #4;
        while ((exp_q[l].size() != 0 || busy[l]) && n < 100) begin
            @(negedge clk);
            #4;
            n++;
        end
        check($sformatf("drain_left_l%0d", l), 64'(exp_q[l].size()), 64'd0);
        check($sformatf("drain_busy_l%0d", l), 64'(busy[l]), 64'd0);
    endtask

    task automatic measure_latency(input int l);
        int cycles;
        rsp_ready[l] = 1'b1;
        @(negedge clk);
        req_valid[l] = 1'b1;
        req_we[l]    = 1'b0;
        req_addr[l]  = 10'd1;
        #2;
        check($sformatf("lat_ready_l%0d", l), 64'(req_ready[l]), 64'd1);
        exp_q[l].push_back(ref_mem[l][1]);
        @(posedge clk);
        #1;
        req_valid[l] = 1'b0;
        cycles = 1;
        @(negedge clk);
        #1;
        while (!rsp_valid[l] && cycles < 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check($sformatf("latency_l%0d", l), 64'(cycles), 64'(lat_of(l) + 1));
        drain(l);
    endtask

    task automatic run_random(input int l, input int n_req);
        bit stop;
        stop = 0;
        fork
            begin
                while (!stop) begin
                    @(negedge clk);
                    rsp_ready[l] = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < n_req; i++) begin
                    int gap;
                    logic we;
                    gap = $urandom_range(0, 2);
                    we  = ($urandom_range(0, 2) == 0);
                    repeat (gap) @(negedge clk);
                    do_req(l, we, 10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
                end
                stop = 1;
            end
        join
        drain(l);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[14];
        bit   took2;
        int   stale;

        vecs[0]  = '{1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 10'd5, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 10'd7, 32'h11223344, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 10'd7, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[4]  = '{1'b0, 10'd7, 32'h0,        4'h0, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 10'd9, 32'hCAFEF00D, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 10'd9, 32'h12000000, 4'h8, 32'h0};
        vecs[7]  = '{1'b0, 10'd9, 32'h0,        4'h0, 32'h12FEF00D};
        vecs[8]  = '{1'b1, 10'd3, 32'h12345678, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 10'd3, 32'h0,        4'h0, 32'hA5C30003};
        vecs[10] = '{1'b0, 10'd5, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 10'd8, 32'h0000FFFF, 4'h3, 32'h0};
        vecs[12] = '{1'b0, 10'd8, 32'h0,        4'h0, 32'hA5C3FFFF};
        vecs[13] = '{1'b0, 10'd2, 32'h0,        4'h0, 32'hA5C30002};

        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < 1024; i++) ref_mem[l][i] = init_word(i);
            req_valid[l] = 1'b1;   // held high during reset: must not be accepted
            req_we[l]    = 1'b1;
            req_addr[l]  = '0;
            req_wdata[l] = '0;
            req_be[l]    = 4'hF;
            rsp_ready[l] = 1'b1;
        end

        // reset values
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #10;
        check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
        check("rst_busy",      64'(busy[0]),      64'd0);
        check("rst_req_ready", 64'(req_ready[0]), 64'd0);
        check("rst_sram_req",  64'(sram_req[0]),  64'd0);
        @(negedge clk);
        for (int l = 0; l < NL; l++) req_valid[l] = 1'b0;
        rst = 1'b0;

        // table-driven writes/reads on lane 0
        for (int i = 0; i < 14; i++) begin
            do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, !vecs[i].we, vecs[i].exp_rdata);
        end
        drain(0);

        // unstalled latency per lane
        for (int l = 0; l < NL; l++) measure_latency(l);

        // backpressure and same-cycle pop credit on lane 0
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 32'h0);
        do_req(0, 1'b0, 10'd1, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'd2;
        #2;
        check("bp_read_blocked", 64'(req_ready[0]), 64'd0);
        check("bp_busy",         64'(busy[0]),      64'd1);
        req_we[0] = 1'b1;
        #1;
        check("bp_write_open",   64'(req_ready[0]), 64'd1);
        req_we[0] = 1'b0;
        #1;
        repeat (2) begin
            @(negedge clk);
            #2;
            check("bp_hold_blocked", 64'(req_ready[0]), 64'd0);
        end
        check("bp_rsp_pending", 64'(rsp_valid[0]), 64'd1);
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        #2;
        took2 = req_ready[0];
        check("pop_frees_credit", 64'(req_ready[0]), 64'd1);
        if (took2) exp_q[0].push_back(ref_mem[0][2]);
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        req_addr[0]  = 10'd3;
        @(negedge clk);
        #2;
        check("bp_used_stays_full", 64'(req_ready[0]), 64'd0);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        if (!took2) do_req(0, 1'b0, 10'd2, 32'h0, 4'h0, 1'b0, 32'h0);
        do_req(0, 1'b0, 10'd3, 32'h0, 4'h0, 1'b0, 32'h0);
        drain(0);

        // random valid/ready streams on Latency=0 and Latency=3
        run_random(1, 150);
        run_random(2, 150);

        // asynchronous reset with reads outstanding on lane 0
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 10'd4, 32'h0, 4'h0, 1'b0, 32'h0);
        do_req(0, 1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'd6;
        #1;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("arst_busy",      64'(busy[0]),      64'd0);
        check("arst_req_ready", 64'(req_ready[0]), 64'd0);
        check("arst_sram_req",  64'(sram_req[0]),  64'd0);
        check("arst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
        req_valid[0] = 1'b0;
        exp_q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid[0]) stale++;
        end
        check("no_stale_rsp", 64'(stale), 64'd0);
        do_req(0, 1'b0, 10'd5, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
